// File: rtl/reg_dump_serializer.sv
// Register-file dump engine: reads registers 0..NUM_REGS-1 through a combinational
// read port and shifts each word out MSB-first on a framed serial line.
module reg_dump_serializer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              bit_strobe,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              sdo_nxt, sdo_valid_nxt, bit_strobe_nxt, busy_nxt, done_nxt;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rd_addr    <= '0;
            sdo        <= 1'b1;
            sdo_valid  <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            rd_addr    <= addr_nxt;
            sdo        <= sdo_nxt;
            sdo_valid  <= sdo_valid_nxt;
            bit_strobe <= bit_strobe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        addr_nxt  = rd_addr;

        if (state != S_IDLE && abort) begin
            state_nxt = S_IDLE;
            div_nxt   = '0;
            bit_nxt   = '0;
            shreg_nxt = '0;
            addr_nxt  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nxt = S_FETCH;
                        addr_nxt  = '0;
                        div_nxt   = '0;
                        bit_nxt   = '0;
                    end
                end
                S_FETCH: begin
                    shreg_nxt = rd_data;
                    state_nxt = S_SHIFT;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nxt   = '0;
                        shreg_nxt = shreg << 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_nxt   = '0;
                            state_nxt = S_GAP;
                        end else begin
                            bit_nxt = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_nxt = div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nxt = '0;
                        if (rd_addr == ADDR_LAST) begin
                            state_nxt = S_DONE;
                        end else begin
                            addr_nxt  = rd_addr + ADDR_W'(1);
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        div_nxt = div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    addr_nxt  = '0;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    addr_nxt  = '0;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        busy_nxt       = (state_nxt != S_IDLE);
        done_nxt       = (state_nxt == S_DONE);
        sdo_valid_nxt  = (state_nxt == S_SHIFT);
        sdo_nxt        = sdo_valid_nxt ? shreg_nxt[DATA_W-1] : 1'b1;
        bit_strobe_nxt = sdo_valid_nxt && (div_nxt == DIV_LAST);
    end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Self-checking bench for reg_dump_serializer: control-vector table, per-cycle
// reference model of full dumps, abort/reset sequences and a CLK_DIV=1 instance.
module tb_reg_dump_serializer;

    localparam int DW  = 16;
    localparam int NR  = 8;
    localparam int CD  = 4;
    localparam int PER = 1 + (DW + 1) * CD;
    localparam int EXP = NR * PER + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n, start, abort, start_b;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        sdo, sdo_valid, bit_strobe, busy, done;
    logic [0:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        sdo_b, sdo_valid_b, bit_strobe_b, busy_b, done_b;

    logic [15:0] regs [NR];
    logic [15:0] reg_b;

    assign rd_data   = regs[rd_addr];
    assign rd_data_b = (rd_addr_b == 1'b0) ? reg_b : 16'hDEAD;

    int tests = 0;
    int fails = 0;

    reg_dump_serializer #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .CLK_DIV(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .sdo(sdo), .sdo_valid(sdo_valid),
        .bit_strobe(bit_strobe), .busy(busy), .done(done)
    );

    reg_dump_serializer #(.DATA_W(16), .NUM_REGS(1), .ADDR_W(1), .CLK_DIV(1)) dut_b (
        .clk(clk), .clr_n(clr_n), .start(start_b), .abort(1'b0),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .sdo(sdo_b), .sdo_valid(sdo_valid_b),
        .bit_strobe(bit_strobe_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       s;
        logic       a;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {busy, done, sdo_valid, sdo, bit_strobe, rd_addr};
    endfunction

    // Full dump checked cycle by cycle against the frame timing derived from the register contents
    task automatic dump_and_check(input string tag, input logic extra);
        int e_sdo, e_val, e_stb, e_addr, e_busy, e_done, ndone, dcyc, nb;
        logic [15:0] acc;
        logic [15:0] words [$];
        logic xval, xsdo, xstb, xbusy, xdone;
        int xaddr, k, off, b;
        e_sdo = 0; e_val = 0; e_stb = 0; e_addr = 0; e_busy = 0; e_done = 0;
        ndone = 0; dcyc = 0; nb = 0; acc = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= EXP + 4; c++) begin
            if (c < EXP) begin
                k     = (c - 1) / PER;
                off   = (c - 1) % PER;
                xval  = (off >= 1) && (off <= DW * CD);
                b     = xval ? (DW - 1 - (off - 1) / CD) : 0;
                xsdo  = xval ? regs[k][b] : 1'b1;
                xstb  = xval && (((off - 1) % CD) == CD - 1);
                xaddr = k;
                xbusy = 1'b1;
                xdone = 1'b0;
            end else if (c == EXP) begin
                xval = 1'b0; xsdo = 1'b1; xstb = 1'b0; xaddr = NR - 1; xbusy = 1'b1; xdone = 1'b1;
            end else begin
                xval = 1'b0; xsdo = 1'b1; xstb = 1'b0; xaddr = 0; xbusy = 1'b0; xdone = 1'b0;
            end
            if (sdo !== xsdo)        e_sdo++;
            if (sdo_valid !== xval)  e_val++;
            if (bit_strobe !== xstb) e_stb++;
            if (int'(rd_addr) != xaddr || $isunknown(rd_addr)) e_addr++;
            if (busy !== xbusy)      e_busy++;
            if (done !== xdone)      e_done++;
            if (done === 1'b1) begin
                ndone++;
                if (dcyc == 0) dcyc = c;
            end
            if (bit_strobe === 1'b1) begin
                acc = {acc[14:0], sdo};
                nb++;
                if (nb % DW == 0) words.push_back(acc);
            end
            start = extra && (c < EXP) && (c % 97 == 50);
            tick();
        end
        start = 1'b0;
        chk({tag, "_sdo_errs"}, e_sdo, 0);
        chk({tag, "_valid_errs"}, e_val, 0);
        chk({tag, "_strobe_errs"}, e_stb, 0);
        chk({tag, "_addr_errs"}, e_addr, 0);
        chk({tag, "_busy_errs"}, e_busy, 0);
        chk({tag, "_done_errs"}, e_done, 0);
        chk({tag, "_done_cycle"}, dcyc, EXP);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_strobe_total"}, nb, NR * DW);
        for (int i = 0; i < words.size() && i < NR; i++)
            chk($sformatf("%s_word%0d", tag, i), words[i], regs[i]);
    endtask

    initial begin
        int nd, nbsy, nstb, first, last, dcyc;
        logic [15:0] acc;

        clr_n = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0;
        reg_b = 16'h0;
        for (int i = 0; i < NR; i++) regs[i] = 16'hA5A0 + 16'(i);
        tick();
        chk("reset_outputs", obs(), 8'h10);
        chk("reset_outputs_b", {busy_b, done_b, sdo_valid_b, sdo_b, bit_strobe_b}, 5'b00010);
        tick();
        clr_n = 1'b1;
        tick();

        // Control vectors: {busy,done,sdo_valid,sdo,bit_strobe,rd_addr} after each edge
        regs[0] = 16'h8001;
        tbl[0] = '{1'b0, 1'b0, 8'h10};
        tbl[1] = '{1'b1, 1'b1, 8'h10};
        tbl[2] = '{1'b0, 1'b1, 8'h10};
        tbl[3] = '{1'b1, 1'b0, 8'h90};
        tbl[4] = '{1'b0, 1'b0, 8'hB0};
        tbl[5] = '{1'b1, 1'b0, 8'hB0};
        tbl[6] = '{1'b0, 1'b0, 8'hB0};
        tbl[7] = '{1'b0, 1'b0, 8'hB8};
        tbl[8] = '{1'b0, 1'b1, 8'h10};
        tbl[9] = '{1'b0, 1'b0, 8'h10};
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].s;
            abort = tbl[i].a;
            tick();
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end
        start = 1'b0; abort = 1'b0;
        tick();

        // Asynchronous reset in the middle of a word
        for (int i = 0; i < NR; i++) regs[i] = 16'hA5A0 + 16'(i);
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        chk("rst_pre_valid", sdo_valid, 1'b1);
        clr_n = 1'b0;
        #1;
        chk("rst_async", obs(), 8'h10);
        repeat (2) tick();
        clr_n = 1'b1;
        nd = 0; nbsy = 0;
        repeat (10) begin
            tick();
            nd += int'(done);
            nbsy += int'(busy);
        end
        chk("rst_no_done", nd, 0);
        chk("rst_no_restart", nbsy, 0);

        dump_and_check("a5a0", 1'b0);

        regs[0] = 16'h0000; regs[1] = 16'hFFFF; regs[7] = 16'h8001;
        for (int i = 2; i < 7; i++) regs[i] = 16'($urandom);
        dump_and_check("edge", 1'b0);

        for (int i = 0; i < NR; i++) regs[i] = 16'hA5A0 + 16'(i);
        dump_and_check("busy_start", 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) regs[i] = 16'($urandom);
            dump_and_check($sformatf("rand%0d", r), r[0]);
        end

        // Abort at word 3, bit 5 (cycle 1 + 3*PER + 1 + 5*CD after start)
        start = 1'b1; tick(); start = 1'b0;
        repeat (3 * PER + 1 + 5 * CD - 1) tick();
        chk("abort_pos_addr", rd_addr, 3'd3);
        chk("abort_pos_valid", sdo_valid, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", obs(), 8'h10);
        nd = 0; nbsy = 0;
        repeat (EXP) begin
            tick();
            nd += int'(done);
            nbsy += int'(busy);
        end
        chk("abort_no_done", nd, 0);
        chk("abort_stays_idle", nbsy, 0);
        dump_and_check("after_abort", 1'b0);

        // CLK_DIV=1, NUM_REGS=1 instance
        reg_b = 16'($urandom) | 16'h8001;
        nstb = 0; first = 0; last = 0; dcyc = 0; acc = '0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (bit_strobe_b === 1'b1) begin
                if (nstb == 0) first = c;
                last = c;
                nstb++;
                acc = {acc[14:0], sdo_b};
            end
            if (done_b === 1'b1 && dcyc == 0) dcyc = c;
            tick();
        end
        chk("div1_strobes", nstb, 16);
        chk("div1_first_strobe", first, 2);
        chk("div1_last_strobe", last, 17);
        chk("div1_done_cycle", dcyc, 19);
        chk("div1_word", acc, reg_b);
        chk("div1_idle_after", {busy_b, sdo_b, sdo_valid_b}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
